// File: rtl/iodec_bank_pkg.sv
// Shared definitions for the internal I/O page decoders: FSM encoding,
// default page bases and register index names.
package iodec_bank_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_WAIT   = 3'd2,
        ST_EXT    = 3'd3,
        ST_ACK    = 3'd4
    } iodec_state_e;

    localparam logic [7:0] BASE_PAGE00 = 8'h00;
    localparam logic [7:0] BASE_PAGE02 = 8'h02;

    // Halfword register indices within a page.
    localparam int unsigned MEMC1 = 'h00;
    localparam int unsigned MEMC2 = 'h01;
    localparam int unsigned HC    = 'h02;
    localparam int unsigned VC    = 'h03;
    localparam int unsigned INT1  = 'h70;

endpackage

// File: rtl/iodec_bank_match.sv
// Page hit and register index from a latched address; shared by every page
// decoder so the match rule lives in one place.
module iodec_bank_match
    import iodec_bank_pkg::*;
#(
    parameter int              AW   = 16,
    parameter logic [AW-9:0]   BASE = BASE_PAGE00,
    parameter int              NREG = 32,
    localparam int             IW   = $clog2(NREG)
) (
    input  logic [AW-1:0] a_i,
    input  logic          intdev_i,
    output logic          hit_o,
    output logic [IW-1:0] idx_o
);

    logic [6:0] off;
    logic       page_ok;
    logic       off_ok;

    // Offset bits above the index must be zero; a page with a
    // non-power-of-two register count also rejects the unused top indices.
    always_comb begin
        off     = a_i[7:1];
        idx_o   = a_i[IW:1];
        page_ok = (a_i[AW-1:8] == BASE);
        off_ok  = ((off >> IW) == 7'd0) && (32'(idx_o) < NREG);
        hit_o   = intdev_i && page_ok && off_ok;
    end

endmodule

// File: rtl/iodec_bank.sv
// Registered decoder for one page of internal registers: sequences each
// access through decode, wait states or external acknowledge, then ack.
module iodec_bank
    import iodec_bank_pkg::*;
#(
    parameter int              AW      = 16,
    parameter logic [AW-9:0]   BASE    = BASE_PAGE00,
    parameter int              NREG    = 32,
    parameter int              WAIT    = 1,
    parameter logic [NREG-1:0] EXTMASK = '0,
    parameter int              TMO     = 15
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic            req,
    input  logic            rw,
    input  logic [AW-1:0]   a,
    input  logic            intdev,
    input  logic            ext_ack,
    output logic            busy,
    output logic [NREG-1:0] rstb,
    output logic [NREG-1:0] wstb,
    output logic            ack,
    output logic            float,
    output logic            err,
    output iodec_state_e    state_o
);

    localparam int         IW         = $clog2(NREG);
    localparam logic [3:0] WCNT_INIT  = 4'(WAIT - 1);
    localparam logic [7:0] TCNT_LAST  = 8'(TMO - 1);

    iodec_state_e    state_q, state_d;
    logic [AW-1:0]   a_q, a_d;
    logic            rw_q, rw_d;
    logic            id_q, id_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic [7:0]      tcnt_q, tcnt_d;
    logic            busy_q, busy_d;
    logic [NREG-1:0] rstb_q, rstb_d;
    logic [NREG-1:0] wstb_q, wstb_d;
    logic            ack_q, ack_d;
    logic            float_q, float_d;
    logic            err_q, err_d;

    logic            hit;
    logic [IW-1:0]   idx;
    logic            ext_sel;

    iodec_bank_match #(
        .AW   (AW),
        .BASE (BASE),
        .NREG (NREG)
    ) u_match (
        .a_i      (a_q),
        .intdev_i (id_q),
        .hit_o    (hit),
        .idx_o    (idx)
    );

    assign ext_sel = EXTMASK[idx];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        rw_d    = rw_q;
        id_d    = id_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        float_d = 1'b0;
        err_d   = 1'b0;
        rstb_d  = '0;
        wstb_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    a_d     = a;
                    rw_d    = rw;
                    id_d    = intdev;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!hit) begin
                    float_d = rw_q;
                    state_d = ST_ACK;
                end else if (ext_sel) begin
                    tcnt_d  = '0;
                    state_d = ST_EXT;
                end else if (WAIT == 0) begin
                    state_d = ST_ACK;
                end else begin
                    wcnt_d  = WCNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = ST_ACK;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_EXT: begin
                // An acknowledge in the timeout cycle still counts as success.
                if (ext_ack) begin
                    state_d = ST_ACK;
                end else if (tcnt_q == TCNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        ack_d  = (state_d == ST_ACK);
        // Read select covers the whole data phase; write commits only at ack.
        if (hit && rw_q && ((state_d == ST_WAIT) || (state_d == ST_EXT) || (state_d == ST_ACK))) begin
            rstb_d[idx] = 1'b1;
        end
        if (hit && !rw_q && (state_d == ST_ACK)) begin
            wstb_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            rw_q    <= 1'b0;
            id_q    <= 1'b0;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            busy_q  <= 1'b0;
            rstb_q  <= '0;
            wstb_q  <= '0;
            ack_q   <= 1'b0;
            float_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            rw_q    <= rw_d;
            id_q    <= id_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            busy_q  <= busy_d;
            rstb_q  <= rstb_d;
            wstb_q  <= wstb_d;
            ack_q   <= ack_d;
            float_q <= float_d;
            err_q   <= err_d;
        end
    end

    assign busy    = busy_q;
    assign rstb    = rstb_q;
    assign wstb    = wstb_q;
    assign ack     = ack_q;
    assign float   = float_q;
    assign err     = err_q;
    assign state_o = state_q;

endmodule
